// File: rtl/mcs4_rom_loader_pkg.sv
// Shared types for the MCS-4 host program loader: ROM address/character types
// and the loader state encoding.
package mcs4_rom_loader_pkg;

  typedef logic [3:0]  char_t;
  typedef logic [7:0]  byte_t;
  typedef logic [11:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_LOAD,
    ST_DRAIN,
    ST_RELEASE,
    ST_FAULT
  } loader_state_e;

endpackage

// File: rtl/mcs4_hold_timer.sv
// Down-counting hold timer: load with N-1 to get an N-cycle hold while enabled.
module mcs4_hold_timer #(
  parameter int             W       = 5,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mcs4_rom_loader.sv
// Host-side program loader: holds the i4004 in reset, streams host bytes into
// the i4001 ROMs over the debug write port, then releases the CPU.
module mcs4_rom_loader
  import mcs4_rom_loader_pkg::*;
#(
  parameter int ROM_CHIPS = 2,
  parameter int HALT_CYC  = 8,
  parameter int HOLD_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_start,
  input  logic             host_abort,
  input  logic [11:0]      host_base,
  input  logic [12:0]      host_len,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [2:0][3:0]  dbg_addr,
  output logic [7:0]       dbg_wdata,
  output logic             dbg_wen,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int            TW_MAX    = (HALT_CYC > HOLD_CYC) ? HALT_CYC : HOLD_CYC;
  localparam int            TW        = $clog2(TW_MAX + 1);
  localparam logic [TW-1:0] HALT_LOAD = TW'(HALT_CYC - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
  localparam logic [13:0]   ROM_BYTES = 14'(ROM_CHIPS * 256);

  loader_state_e state, next;
  addr_t         addr;
  logic [12:0]   remaining;
  logic          boot;
  logic          halt_exp, rel_exp;
  logic          range_bad, xfer, accept_start, release_end;

  assign range_bad   = ({2'b00, host_base} + {1'b0, host_len}) > ROM_BYTES;
  assign s_ready     = (state == ST_LOAD) && (remaining != '0);
  assign xfer        = s_valid && s_ready;
  assign busy        = (state != ST_IDLE);
  assign cpu_rst     = (state != ST_IDLE);
  assign release_end = (state == ST_RELEASE) && rel_exp;

  mcs4_hold_timer #(.W(TW), .RST_VAL('0)) u_halt_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_start && !range_bad),
    .load_val (HALT_LOAD),
    .en       (state == ST_HALT),
    .expired  (halt_exp)
  );

  // Reset lands in RELEASE, so this timer starts pre-loaded with the hold time.
  mcs4_hold_timer #(.W(TW), .RST_VAL(HOLD_LOAD)) u_rel_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_DRAIN),
    .load_val (HOLD_LOAD),
    .en       (state == ST_RELEASE),
    .expired  (rel_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RELEASE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next         = state;
    accept_start = 1'b0;
    unique case (state)
      ST_IDLE, ST_FAULT: begin
        if (host_start) begin
          accept_start = 1'b1;
          next         = range_bad ? ST_FAULT : ST_HALT;
        end
      end
      ST_HALT: begin
        if (host_abort)    next = ST_FAULT;
        else if (halt_exp) next = (remaining == '0) ? ST_DRAIN : ST_LOAD;
      end
      ST_LOAD: begin
        if (host_abort)                         next = ST_FAULT;
        else if (xfer && remaining == 13'd1)    next = ST_DRAIN;
      end
      ST_DRAIN:   next = ST_RELEASE;
      ST_RELEASE: if (rel_exp) next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  // A byte accepted this cycle is written on the following cycle, so an
  // abort never truncates a write that is already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
      boot      <= 1'b1;
      err       <= 1'b0;
      done      <= 1'b0;
      dbg_wen   <= 1'b0;
      dbg_addr  <= '0;
      dbg_wdata <= '0;
    end else begin
      dbg_wen <= xfer;
      done    <= release_end && !boot;
      err     <= accept_start ? range_bad : (err || next == ST_FAULT);
      if (release_end) boot <= 1'b0;
      if (accept_start) begin
        addr      <= host_base;
        remaining <= host_len;
      end else if (xfer) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (xfer) begin
        dbg_addr  <= addr;
        dbg_wdata <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_rom_loader.sv
// Self-checking bench for mcs4_rom_loader: randomized host streams checked
// against a queue-based model of the expected ROM writes and phase timing.
module tb_mcs4_rom_loader;

  localparam int ROM_CHIPS = 2;
  localparam int HALT_CYC  = 8;
  localparam int HOLD_CYC  = 16;

  logic            clk, rst, host_start, host_abort;
  logic [11:0]     host_base;
  logic [12:0]     host_len;
  logic            s_valid, s_ready, dbg_wen, cpu_rst, busy, done, err;
  logic [7:0]      s_data, dbg_wdata;
  logic [2:0][3:0] dbg_addr;

  mcs4_rom_loader #(.ROM_CHIPS(ROM_CHIPS), .HALT_CYC(HALT_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_start (host_start),
    .host_abort (host_abort),
    .host_base  (host_base),
    .host_len   (host_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_wen    (dbg_wen),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int          cyc;
    logic [11:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t        wr_q[$];
  ev_t        acc_q[$];
  logic [7:0] tx_q[$];
  int         cyc, done_cnt;
  int         n_cmp, n_fail;
  int         halt_n, rel_n, n_acc;
  bit         done_at_rel;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe the DUT between active edges: accepted bytes, ROM writes, done pulses.
  always @(negedge clk) begin
    ev_t e;
    if (s_valid && s_ready) begin
      e.cyc = cyc; e.a = '0; e.d = s_data;
      acc_q.push_back(e);
    end
    if (dbg_wen) begin
      e.cyc = cyc; e.a = dbg_addr; e.d = dbg_wdata;
      wr_q.push_back(e);
    end
    if (done) done_cnt++;
  end

  task automatic pulse_start(input logic [11:0] base, input logic [12:0] len);
    host_base  = base;
    host_len   = len;
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
  endtask

  // Drives one complete load transaction and records phase lengths; no checking here.
  task automatic drive_load(input logic [11:0] base, input logic [12:0] len, input logic [31:0] pat,
                            input int pat_len, input bit rnd, input int abort_after, input int ign_at);
    int c;
    bit took, ign_done;
    wr_q.delete(); acc_q.delete();
    done_cnt = 0; halt_n = 0; rel_n = 0; n_acc = 0; done_at_rel = 0; ign_done = 0;
    pulse_start(base, len);
    if (len != 0) begin
      while (!s_ready && halt_n < 64) begin @(posedge clk); #1; halt_n++; end
      c = 0;
      while (n_acc < int'(len) && n_acc != abort_after && c < 256) begin
        s_data  = tx_q[n_acc];
        s_valid = rnd ? 1'($urandom_range(0, 1)) : ((c < pat_len) ? pat[c] : 1'b1);
        if (!ign_done && n_acc == ign_at) begin
          host_start = 1'b1; host_base = base ^ 12'h0FF; host_len = 13'd1; ign_done = 1;
        end
        @(negedge clk);
        took = s_valid && s_ready;
        @(posedge clk); #1;
        host_start = 1'b0;
        c++;
        if (took) n_acc++;
      end
      s_valid = 1'b0;
    end
    if (abort_after >= 0) begin
      host_abort = 1'b1;
      @(posedge clk); #1;
      host_abort = 1'b0;
      repeat (HOLD_CYC + 4) @(posedge clk);
      @(negedge clk);
    end else begin
      while (cpu_rst && rel_n < 128) begin @(posedge clk); #1; rel_n++; end
      done_at_rel = done;
      repeat (3) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (s_ready !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (dbg_wen !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_dbg_wen: got %b want 0", dbg_wen); end
    n_cmp++; if (dbg_addr !== 12'h0) begin n_fail++; $display("[TB] FAIL reset_dbg_addr: got %h want 000", dbg_addr); end
    n_cmp++; if (dbg_wdata !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_dbg_wdata: got %h want 00", dbg_wdata); end
    n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done_err: got %b want 00", {done, err}); end
    wr_q.delete(); done_cnt = 0; n = 0;
    rst = 1'b1;
    while (cpu_rst && n < 64) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== HOLD_CYC) begin n_fail++; $display("[TB] FAIL boot_hold: got %0d clocks want %0d", n, HOLD_CYC); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("[TB] FAIL boot_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (wr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL boot_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_busy: got %b want 0", busy); end
  endtask

  task automatic test_load(input string tag, input logic [11:0] base, input logic [12:0] len,
                           input logic [31:0] pat, input int pat_len, input bit rnd, input int ign_at,
                           input logic [7:0] b0, input bit inc);
    tx_q.delete();
    for (int i = 0; i < int'(len); i++) tx_q.push_back(inc ? 8'(int'(b0) + i) : 8'($urandom));
    drive_load(base, len, pat, pat_len, rnd, -1, ign_at);
    n_cmp++; if (n_acc !== int'(len)) begin n_fail++; $display("[TB] FAIL %s_accepted: got %0d want %0d", tag, n_acc, len); end
    n_cmp++; if (halt_n !== HALT_CYC) begin n_fail++; $display("[TB] FAIL %s_halt: got %0d want %0d", tag, halt_n, HALT_CYC); end
    n_cmp++; if (rel_n !== HOLD_CYC + 1) begin n_fail++; $display("[TB] FAIL %s_release: got %0d want %0d", tag, rel_n, HOLD_CYC + 1); end
    n_cmp++; if (done_at_rel !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_done_edge: got %b want 1", tag, done_at_rel); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
    n_cmp++; if (wr_q.size() !== int'(len)) begin n_fail++; $display("[TB] FAIL %s_writes: got %0d want %0d", tag, wr_q.size(), len); end
    for (int i = 0; i < wr_q.size() && i < tx_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].a !== 12'(int'(base) + i) || wr_q[i].d !== tx_q[i]) begin
        n_fail++;
        $display("[TB] FAIL %s_write%0d: got %h/%h want %h/%h", tag, i, wr_q[i].a, wr_q[i].d, 12'(int'(base) + i), tx_q[i]);
      end
      if (i < acc_q.size()) begin
        n_cmp++;
        if (wr_q[i].cyc !== acc_q[i].cyc + 1) begin
          n_fail++; $display("[TB] FAIL %s_latency%0d: got cycle %0d want %0d", tag, i, wr_q[i].cyc, acc_q[i].cyc + 1);
        end
      end
      if (!rnd && pat_len == 0) begin
        n_cmp++;
        if (wr_q[i].cyc !== wr_q[0].cyc + i) begin
          n_fail++; $display("[TB] FAIL %s_b2b%0d: got cycle %0d want %0d", tag, i, wr_q[i].cyc, wr_q[0].cyc + i);
        end
      end
    end
    n_cmp++; if ({err, cpu_rst, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL %s_final: got %b want 000", tag, {err, cpu_rst, busy}); end
  endtask

  task automatic test_range();
    wr_q.delete(); acc_q.delete(); done_cnt = 0;
    s_valid = 1'b1; s_data = 8'h77;
    pulse_start(12'h1FE, 13'd4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({err, cpu_rst, busy} !== 3'b111) begin n_fail++; $display("[TB] FAIL range_fault: got %b want 111", {err, cpu_rst, busy}); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL range_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (wr_q.size() + acc_q.size() !== 0) begin n_fail++; $display("[TB] FAIL range_writes: got %0d want 0", wr_q.size() + acc_q.size()); end
    s_valid = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    drive_load(12'h1FC, 13'd4, 32'h0, 0, 1'b0, -1, -1);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL range_err_clear: got %b want 0", err); end
    n_cmp++; if (wr_q.size() !== 4) begin n_fail++; $display("[TB] FAIL range_recover_writes: got %0d want 4", wr_q.size()); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL range_recover_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
    drive_load(12'h030, 13'd8, 32'h0, 0, 1'b0, 2, -1);
    n_cmp++; if (wr_q.size() !== 2) begin n_fail++; $display("[TB] FAIL abort_writes: got %0d want 2", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 2; i++) begin
      n_cmp++;
      if (wr_q[i].a !== 12'(12'h030 + i) || wr_q[i].d !== tx_q[i]) begin
        n_fail++; $display("[TB] FAIL abort_write%0d: got %h/%h want %h/%h", i, wr_q[i].a, wr_q[i].d, 12'(12'h030 + i), tx_q[i]);
      end
    end
    n_cmp++; if ({err, cpu_rst, busy} !== 3'b111) begin n_fail++; $display("[TB] FAIL abort_fault: got %b want 111", {err, cpu_rst, busy}); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("[TB] FAIL abort_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_len0();
    tx_q.delete();
    drive_load(12'h155, 13'd0, 32'h0, 0, 1'b0, -1, -1);
    n_cmp++; if (rel_n !== HALT_CYC + 1 + HOLD_CYC) begin n_fail++; $display("[TB] FAIL len0_timing: got %0d want %0d", rel_n, HALT_CYC + 1 + HOLD_CYC); end
    n_cmp++; if (done_at_rel !== 1'b1 || done_cnt !== 1) begin n_fail++; $display("[TB] FAIL len0_done: got %b/%0d want 1/1", done_at_rel, done_cnt); end
    n_cmp++; if (wr_q.size() + acc_q.size() !== 0) begin n_fail++; $display("[TB] FAIL len0_writes: got %0d want 0", wr_q.size() + acc_q.size()); end
  endtask

  task automatic test_reset_midload();
    int n;
    pulse_start(12'h0A5, 13'd6);
    n = 0;
    while (!s_ready && n < 64) begin @(posedge clk); #1; n++; end
    s_data = 8'h5A; s_valid = 1'b1;
    @(posedge clk); #2;
    n_cmp++; if (dbg_wen !== 1'b1 || dbg_addr !== 12'h0A5) begin n_fail++; $display("[TB] FAIL midload_write: got %b/%h want 1/0a5", dbg_wen, dbg_addr); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({dbg_wen, s_ready, done, err} !== 4'b0000) begin n_fail++; $display("[TB] FAIL midload_ctrl: got %b want 0000", {dbg_wen, s_ready, done, err}); end
    n_cmp++; if (dbg_addr !== 12'h0 || dbg_wdata !== 8'h0) begin n_fail++; $display("[TB] FAIL midload_data: got %h/%h want 000/00", dbg_addr, dbg_wdata); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL midload_cpu_rst: got %b want 1", cpu_rst); end
    s_valid = 1'b0;
    @(negedge clk);
    wr_q.delete(); done_cnt = 0; n = 0;
    rst = 1'b1;
    while (cpu_rst && n < 64) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (n !== HOLD_CYC) begin n_fail++; $display("[TB] FAIL midload_hold: got %0d want %0d", n, HOLD_CYC); end
    n_cmp++; if (done_cnt !== 0 || wr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL midload_quiet: got %0d/%0d want 0/0", done_cnt, wr_q.size()); end
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len, base;
    clk = 1'b0; rst = 1'b0; host_start = 1'b0; host_abort = 1'b0;
    host_base = '0; host_len = '0; s_valid = 1'b0; s_data = '0;
    n_cmp = 0; n_fail = 0; cyc = 0; done_cnt = 0;
    test_reset();
    test_load("load", 12'h0F0, 13'd4, 32'h0, 0, 1'b0, -1, 8'hA1, 1'b1);
    test_load("throttle", 12'h040, 13'd3, 32'h19, 5, 1'b0, -1, 8'h00, 1'b0);
    test_load("start_ignored", 12'h120, 13'd6, 32'h0, 0, 1'b0, 2, 8'h10, 1'b1);
    test_load("top_edge", 12'h1FC, 13'd4, 32'h0, 0, 1'b1, -1, 8'h00, 1'b0);
    test_range();
    test_abort();
    test_load("after_abort", 12'h000, 13'd5, 32'h0, 0, 1'b0, -1, 8'h00, 1'b0);
    test_len0();
    for (int i = 0; i < 4; i++) begin
      len  = $urandom_range(1, 24);
      base = $urandom_range(0, ROM_CHIPS * 256 - len);
      test_load("random", 12'(base), 13'(len), 32'h0, 0, 1'b1, -1, 8'h00, 1'b0);
    end
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
